// File: rtl/interrupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_responder
// Description : TLX-side responder for AP interrupt requests. Accepts
//               intrp_req commands, answers with intrp_resp (and intrp_rdy
//               after a pending response) according to a programmable policy,
//               and logs every delivered interrupt in a small FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_responder #(
  parameter int unsigned RSP_LATENCY = 4,   // 1..255
  parameter int unsigned RDY_DELAY   = 16,  // 1..65535
  parameter int unsigned LOG_DEPTH   = 4    // power of 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tlx_cmd_valid,
  input  logic [7:0]  tlx_cmd_opcode,
  input  logic [67:0] tlx_cmd_obj,
  input  logic [15:0] tlx_cmd_afutag,
  input  logic [19:0] tlx_cmd_pasid,
  input  logic [11:0] tlx_cmd_actag,
  output logic        tlx_rsp_valid,
  output logic [7:0]  tlx_rsp_opcode,
  output logic [3:0]  tlx_rsp_code,
  output logic [15:0] tlx_rsp_afutag,
  input  logic [1:0]  cfg_mode,
  input  logic [3:0]  cfg_retry_num,
  input  logic        cfg_rdy_retry,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [63:0] log_src,
  output logic [19:0] log_pasid,
  output logic [11:0] log_actag,
  output logic        busy,
  output logic        err_overlap,
  output logic [31:0] delivered_cnt
);

  localparam logic [7:0]  c_op_resp  = 8'h0C;
  localparam logic [7:0]  c_op_rdy   = 8'h1A;
  localparam logic [7:0]  c_op_intrp = 8'h58;
  localparam logic [3:0]  c_done     = 4'h0;
  localparam logic [3:0]  c_retry    = 4'h2;
  localparam logic [3:0]  c_pending  = 4'h4;
  localparam logic [3:0]  c_failed   = 4'hE;
  localparam logic [15:0] c_lat_load = 16'(RSP_LATENCY - 1);
  localparam logic [15:0] c_rdy_load = 16'(RDY_DELAY - 1);
  localparam int unsigned c_ptr_w    = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
  localparam int unsigned c_cnt_w    = $clog2(LOG_DEPTH + 1);
  localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(LOG_DEPTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(LOG_DEPTH);

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_DELAY    = 5'b00010,
    ST_RESP     = 5'b00100,
    ST_RDY_WAIT = 5'b01000,
    ST_RDY      = 5'b10000
  } state_e;

  state_e        state_q;
  logic [15:0]   cnt_q;
  logic [7:0]    op_q;
  logic          obj_bad_q;
  logic [63:0]   src_q;
  logic [15:0]   tag_q;
  logic [19:0]   pasid_q;
  logic [11:0]   actag_q;
  logic [1:0]    mode_q;
  logic [3:0]    retry_num_q;
  logic          rdy_retry_q;
  logic [3:0]    retry_cnt_q;
  logic          pend_served_q;
  logic          rdy_retry_used_q;
  logic          err_overlap_q;
  logic [31:0]   delivered_cnt_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_opcode_q;
  logic [3:0]    rsp_code_q;
  logic [15:0]   rsp_afutag_q;

  logic [95:0]         mem_q [LOG_DEPTH];
  logic [c_ptr_w-1:0]  wr_ptr_q;
  logic [c_ptr_w-1:0]  rd_ptr_q;
  logic [c_cnt_w-1:0]  count_q;
  logic [c_cnt_w-1:0]  count_d;

  logic        w_cmd_legal;
  logic        w_full;
  logic        w_resp_fire;
  logic        w_push;
  logic        w_pop;
  logic [3:0]  w_code;
  logic        w_retry_inc;
  logic        w_set_pend;
  logic        w_rdy_issue;
  logic        w_rdy_retry_now;
  logic [3:0]  w_rdy_code;
  logic [95:0] w_head;

  // 0x58..0x5B are the interrupt-request family accepted by this responder
  assign w_cmd_legal = tlx_cmd_valid && (tlx_cmd_opcode[7:2] == 6'b010110);
  assign w_full      = (count_q == c_cnt_full);
  assign w_resp_fire = (state_q == ST_DELAY) && (cnt_q == 16'd0);
  assign w_push      = w_resp_fire && (w_code == c_done);
  assign w_pop       = log_valid && log_ready;

  // The RDY_DELAY countdown starts in the RESP cycle, so RESP itself may issue rdy
  assign w_rdy_issue = (cnt_q == 16'd0) &&
                       (((state_q == ST_RESP) && (rsp_code_q == c_pending)) ||
                        (state_q == ST_RDY_WAIT));
  assign w_rdy_retry_now = rdy_retry_q && !rdy_retry_used_q;
  assign w_rdy_code      = w_rdy_retry_now ? c_retry : c_done;

  // Response code decision in priority order; FIFO fullness is taken before any pop
  always_comb begin
    w_code      = c_done;
    w_retry_inc = 1'b0;
    w_set_pend  = 1'b0;
    if ((op_q != c_op_intrp) || obj_bad_q) begin
      w_code = c_failed;
    end else if (mode_q == 2'd3) begin
      w_code = c_failed;
    end else if ((mode_q == 2'd1) && (retry_cnt_q < retry_num_q)) begin
      w_code      = c_retry;
      w_retry_inc = 1'b1;
    end else if ((mode_q == 2'd2) && !pend_served_q) begin
      w_code     = c_pending;
      w_set_pend = 1'b1;
    end else if (w_full) begin
      w_code = c_retry;
    end
  end

  // Command sequencing, policy state and registered response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      op_q             <= '0;
      obj_bad_q        <= 1'b0;
      src_q            <= '0;
      tag_q            <= '0;
      pasid_q          <= '0;
      actag_q          <= '0;
      mode_q           <= '0;
      retry_num_q      <= '0;
      rdy_retry_q      <= 1'b0;
      retry_cnt_q      <= '0;
      pend_served_q    <= 1'b0;
      rdy_retry_used_q <= 1'b0;
      err_overlap_q    <= 1'b0;
      delivered_cnt_q  <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_opcode_q     <= '0;
      rsp_code_q       <= '0;
      rsp_afutag_q     <= '0;
    end else begin
      if (w_cmd_legal && (state_q != ST_IDLE)) begin
        err_overlap_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (w_cmd_legal) begin
            state_q     <= ST_DELAY;
            cnt_q       <= c_lat_load;
            op_q        <= tlx_cmd_opcode;
            obj_bad_q   <= |tlx_cmd_obj[67:64];
            src_q       <= tlx_cmd_obj[63:0];
            tag_q       <= tlx_cmd_afutag;
            pasid_q     <= tlx_cmd_pasid;
            actag_q     <= tlx_cmd_actag;
            mode_q      <= cfg_mode;
            retry_num_q <= cfg_retry_num;
            rdy_retry_q <= cfg_rdy_retry;
          end
        end
        ST_DELAY: begin
          if (cnt_q == 16'd0) begin
            state_q      <= ST_RESP;
            cnt_q        <= c_rdy_load;
            rsp_valid_q  <= 1'b1;
            rsp_opcode_q <= c_op_resp;
            rsp_code_q   <= w_code;
            rsp_afutag_q <= tag_q;
            if (w_retry_inc) begin
              retry_cnt_q <= retry_cnt_q + 4'd1;
            end
            if (w_set_pend) begin
              pend_served_q <= 1'b1;
            end
            if (w_code == c_done) begin
              delivered_cnt_q  <= delivered_cnt_q + 32'd1;
              retry_cnt_q      <= '0;
              pend_served_q    <= 1'b0;
              rdy_retry_used_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_RESP: begin
          rsp_valid_q  <= 1'b0;
          rsp_opcode_q <= '0;
          rsp_code_q   <= '0;
          rsp_afutag_q <= '0;
          if (rsp_code_q == c_pending) begin
            state_q <= ST_RDY_WAIT;
            cnt_q   <= cnt_q - 16'd1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RDY_WAIT: begin
          cnt_q <= cnt_q - 16'd1;
        end
        ST_RDY: begin
          state_q      <= ST_IDLE;
          rsp_valid_q  <= 1'b0;
          rsp_opcode_q <= '0;
          rsp_code_q   <= '0;
          rsp_afutag_q <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
      // Issuing intrp_rdy overrides the RESP/RDY_WAIT defaults above
      if (w_rdy_issue) begin
        state_q          <= ST_RDY;
        cnt_q            <= '0;
        rsp_valid_q      <= 1'b1;
        rsp_opcode_q     <= c_op_rdy;
        rsp_code_q       <= w_rdy_code;
        rsp_afutag_q     <= tag_q;
        rdy_retry_used_q <= rdy_retry_used_q | w_rdy_retry_now;
      end
    end
  end

  // Log occupancy: a push is only ever decided when the FIFO is not full
  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop) begin
      count_d = count_q + 1'b1;
    end else if (!w_push && w_pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Log FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (w_push) begin
        wr_ptr_q <= (wr_ptr_q == c_ptr_last) ? '0 : wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= (rd_ptr_q == c_ptr_last) ? '0 : rd_ptr_q + 1'b1;
      end
    end
  end

  // Log FIFO storage; contents are masked at the outputs while empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_q[wr_ptr_q] <= {src_q, pasid_q, actag_q};
    end
  end

  assign w_head         = mem_q[rd_ptr_q];
  assign log_valid      = (count_q != '0);
  assign log_src        = log_valid ? w_head[95:32] : 64'd0;
  assign log_pasid      = log_valid ? w_head[31:12] : 20'd0;
  assign log_actag      = log_valid ? w_head[11:0]  : 12'd0;

  assign tlx_rsp_valid  = rsp_valid_q;
  assign tlx_rsp_opcode = rsp_opcode_q;
  assign tlx_rsp_code   = rsp_code_q;
  assign tlx_rsp_afutag = rsp_afutag_q;
  assign busy           = (state_q != ST_IDLE);
  assign err_overlap    = err_overlap_q;
  assign delivered_cnt  = delivered_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_responder
// Description : Directed self-checking bench for interrupt_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tlx_cmd_valid;
  logic [7:0]  tlx_cmd_opcode;
  logic [67:0] tlx_cmd_obj;
  logic [15:0] tlx_cmd_afutag;
  logic [19:0] tlx_cmd_pasid;
  logic [11:0] tlx_cmd_actag;
  logic        tlx_rsp_valid;
  logic [7:0]  tlx_rsp_opcode;
  logic [3:0]  tlx_rsp_code;
  logic [15:0] tlx_rsp_afutag;
  logic [1:0]  cfg_mode;
  logic [3:0]  cfg_retry_num;
  logic        cfg_rdy_retry;
  logic        log_valid;
  logic        log_ready;
  logic [63:0] log_src;
  logic [19:0] log_pasid;
  logic [11:0] log_actag;
  logic        busy;
  logic        err_overlap;
  logic [31:0] delivered_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  interrupt_responder #(
    .RSP_LATENCY(4),
    .RDY_DELAY  (16),
    .LOG_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .tlx_cmd_valid (tlx_cmd_valid),
    .tlx_cmd_opcode(tlx_cmd_opcode),
    .tlx_cmd_obj   (tlx_cmd_obj),
    .tlx_cmd_afutag(tlx_cmd_afutag),
    .tlx_cmd_pasid (tlx_cmd_pasid),
    .tlx_cmd_actag (tlx_cmd_actag),
    .tlx_rsp_valid (tlx_rsp_valid),
    .tlx_rsp_opcode(tlx_rsp_opcode),
    .tlx_rsp_code  (tlx_rsp_code),
    .tlx_rsp_afutag(tlx_rsp_afutag),
    .cfg_mode      (cfg_mode),
    .cfg_retry_num (cfg_retry_num),
    .cfg_rdy_retry (cfg_rdy_retry),
    .log_valid     (log_valid),
    .log_ready     (log_ready),
    .log_src       (log_src),
    .log_pasid     (log_pasid),
    .log_actag     (log_actag),
    .busy          (busy),
    .err_overlap   (err_overlap),
    .delivered_cnt (delivered_cnt)
  );

  // One-cycle command; optionally waits (bounded) for the responder to go idle
  task automatic send_cmd(input logic [7:0] op, input logic [67:0] obj,
                          input logic [15:0] tag, input bit wait_idle);
    int k;
    k = 0;
    @(negedge clk);
    if (wait_idle) begin
      while (busy && k < 200) begin
        @(negedge clk);
        k++;
      end
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_wait: busy=%b required 0", busy);
      end
    end
    tlx_cmd_valid  = 1'b1;
    tlx_cmd_opcode = op;
    tlx_cmd_obj    = obj;
    tlx_cmd_afutag = tag;
    tlx_cmd_pasid  = {4'h5, tag};
    tlx_cmd_actag  = tag[11:0];
    @(negedge clk);
    tlx_cmd_valid  = 1'b0;
  endtask

  // Bounded wait for the next response strobe; n counts rising edges waited
  task automatic wait_rsp(input int limit, output bit got, output int n,
                          output logic [7:0] op, output logic [3:0] code,
                          output logic [15:0] tag);
    got = 1'b0; n = 0; op = '0; code = '0; tag = '0;
    while (!got && n < limit) begin
      @(posedge clk);
      #1;
      n++;
      if (tlx_rsp_valid) begin
        got  = 1'b1;
        op   = tlx_rsp_opcode;
        code = tlx_rsp_code;
        tag  = tlx_rsp_afutag;
      end
    end
  endtask

  task automatic pop_log();
    @(negedge clk);
    log_ready = 1'b1;
    @(negedge clk);
    log_ready = 1'b0;
  endtask

  task automatic test_reset();
    tlx_cmd_valid = 0; tlx_cmd_opcode = 0; tlx_cmd_obj = 0; tlx_cmd_afutag = 0;
    tlx_cmd_pasid = 0; tlx_cmd_actag = 0; cfg_mode = 0; cfg_retry_num = 0;
    cfg_rdy_retry = 0; log_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({tlx_rsp_valid, tlx_rsp_opcode, tlx_rsp_code, tlx_rsp_afutag} !== 29'd0) begin
      fails++; $display("FAIL reset_rsp: got %h required 0",
                        {tlx_rsp_valid, tlx_rsp_opcode, tlx_rsp_code, tlx_rsp_afutag});
    end
    tests++;
    if ({log_valid, log_src, log_pasid, log_actag, busy, err_overlap, delivered_cnt} !== 131'd0) begin
      fails++; $display("FAIL reset_misc: log_valid=%b busy=%b err=%b cnt=%0d required all 0",
                        log_valid, busy, err_overlap, delivered_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode0();
    bit got; int n; logic [7:0] op; logic [3:0] code; logic [15:0] tag;
    cfg_mode = 2'd0;
    send_cmd(8'h58, 68'h1234, 16'hC000, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || n != 4) begin
      fails++; $display("FAIL m0_latency: got=%b cycles=%0d required 1/4", got, n);
    end
    tests++;
    if ({op, code, tag} !== {8'h0C, 4'h0, 16'hC000}) begin
      fails++; $display("FAIL m0_rsp: op=%h code=%h tag=%h required 0c/0/c000", op, code, tag);
    end
    @(posedge clk); #1;
    tests++;
    if (tlx_rsp_valid !== 1'b0) begin
      fails++; $display("FAIL m0_strobe_width: valid=%b required 0", tlx_rsp_valid);
    end
    @(negedge clk);
    tests++;
    if ({log_valid, log_src, log_pasid, log_actag} !== {1'b1, 64'h1234, 20'h5C000, 12'h000}) begin
      fails++; $display("FAIL m0_log: valid=%b src=%h pasid=%h actag=%h required 1/1234/5c000/000",
                        log_valid, log_src, log_pasid, log_actag);
    end
    tests++;
    if (delivered_cnt !== 32'd1) begin
      fails++; $display("FAIL m0_delivered: got %0d required 1", delivered_cnt);
    end
    pop_log();
    tests++;
    if (log_valid !== 1'b0) begin
      fails++; $display("FAIL m0_pop: log_valid=%b required 0", log_valid);
    end
  endtask

  task automatic test_mode1_retry();
    bit got; int n; logic [7:0] op; logic [3:0] code; logic [15:0] tag;
    logic [3:0] exp_code [3];
    exp_code[0] = 4'h2; exp_code[1] = 4'h2; exp_code[2] = 4'h0;
    cfg_mode = 2'd1; cfg_retry_num = 4'd2;
    for (int i = 0; i < 3; i++) begin
      send_cmd(8'h58, 68'h77, 16'h0100, 1);
      wait_rsp(20, got, n, op, code, tag);
      tests++;
      if (got !== 1'b1 || code !== exp_code[i] || op !== 8'h0C) begin
        fails++; $display("FAIL m1_try%0d: got=%b op=%h code=%h required 1/0c/%h",
                          i, got, op, code, exp_code[i]);
      end
    end
    @(negedge clk);
    tests++;
    if (delivered_cnt !== 32'd2 || log_valid !== 1'b1 || log_src !== 64'h77) begin
      fails++; $display("FAIL m1_log: cnt=%0d valid=%b src=%h required 2/1/77",
                        delivered_cnt, log_valid, log_src);
    end
    pop_log();
    tests++;
    if (log_valid !== 1'b0) begin
      fails++; $display("FAIL m1_single_entry: log_valid=%b required 0", log_valid);
    end
  endtask

  task automatic test_mode2(input bit rdy_retry, input logic [31:0] exp_cnt);
    bit got; int n; logic [7:0] op; logic [3:0] code; logic [15:0] tag;
    logic [3:0] exp_rdy;
    exp_rdy = rdy_retry ? 4'h2 : 4'h0;
    cfg_mode = 2'd2; cfg_rdy_retry = rdy_retry;
    send_cmd(8'h58, 68'h2000, 16'h2200, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || {op, code} !== {8'h0C, 4'h4}) begin
      fails++; $display("FAIL m2_pending(r%0d): got=%b op=%h code=%h required 1/0c/4",
                        rdy_retry, got, op, code);
    end
    wait_rsp(40, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || n != 16) begin
      fails++; $display("FAIL m2_rdy_delay(r%0d): got=%b cycles=%0d required 1/16", rdy_retry, got, n);
    end
    tests++;
    if ({op, code, tag} !== {8'h1A, exp_rdy, 16'h2200}) begin
      fails++; $display("FAIL m2_rdy(r%0d): op=%h code=%h tag=%h required 1a/%h/2200",
                        rdy_retry, op, code, tag, exp_rdy);
    end
    send_cmd(8'h58, 68'h2000, 16'h2201, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || {op, code, tag} !== {8'h0C, 4'h0, 16'h2201}) begin
      fails++; $display("FAIL m2_resend(r%0d): got=%b op=%h code=%h tag=%h required 1/0c/0/2201",
                        rdy_retry, got, op, code, tag);
    end
    @(negedge clk);
    tests++;
    if (delivered_cnt !== exp_cnt) begin
      fails++; $display("FAIL m2_delivered(r%0d): got %0d required %0d", rdy_retry, delivered_cnt, exp_cnt);
    end
    pop_log();
    cfg_rdy_retry = 1'b0;
  endtask

  task automatic test_failed();
    bit got; int n; logic [7:0] op; logic [3:0] code; logic [15:0] tag;
    cfg_mode = 2'd0;
    send_cmd(8'h5A, 68'h1, 16'h0E01, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || {op, code} !== {8'h0C, 4'hE}) begin
      fails++; $display("FAIL fail_opcode: got=%b op=%h code=%h required 1/0c/e", got, op, code);
    end
    send_cmd(8'h58, 68'h1_0000_0000_0000_0001, 16'h0E02, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || code !== 4'hE) begin
      fails++; $display("FAIL fail_objhi: got=%b code=%h required 1/e", got, code);
    end
    cfg_mode = 2'd3;
    send_cmd(8'h58, 68'h3, 16'h0E03, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || code !== 4'hE || tag !== 16'h0E03) begin
      fails++; $display("FAIL fail_mode3: got=%b code=%h tag=%h required 1/e/0e03", got, code, tag);
    end
    @(negedge clk);
    tests++;
    if (log_valid !== 1'b0 || delivered_cnt !== 32'd4) begin
      fails++; $display("FAIL fail_nolog: valid=%b cnt=%0d required 0/4", log_valid, delivered_cnt);
    end
    cfg_mode = 2'd0;
  endtask

  task automatic test_ignore_opcode();
    bit got; int n; logic [7:0] op; logic [3:0] code; logic [15:0] tag;
    send_cmd(8'h10, 68'h5, 16'h0010, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b0 || busy !== 1'b0 || err_overlap !== 1'b0) begin
      fails++; $display("FAIL ignore_opcode: rsp=%b busy=%b err=%b required 0/0/0", got, busy, err_overlap);
    end
  endtask

  task automatic test_back_to_back();
    bit got; int n; logic [7:0] op; logic [3:0] code; logic [15:0] tag;
    send_cmd(8'h58, 68'h11, 16'h1111, 1);
    send_cmd(8'h58, 68'h22, 16'h2222, 0);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || {code, tag} !== {4'h0, 16'h1111}) begin
      fails++; $display("FAIL b2b_first: got=%b code=%h tag=%h required 1/0/1111", got, code, tag);
    end
    tests++;
    if (err_overlap !== 1'b1) begin
      fails++; $display("FAIL b2b_err_overlap: got %b required 1", err_overlap);
    end
    wait_rsp(25, got, n, op, code, tag);
    tests++;
    if (got !== 1'b0) begin
      fails++; $display("FAIL b2b_dropped: extra rsp tag=%h required none", tag);
    end
    tests++;
    if (delivered_cnt !== 32'd5 || log_src !== 64'h11) begin
      fails++; $display("FAIL b2b_log: cnt=%0d src=%h required 5/11", delivered_cnt, log_src);
    end
    pop_log();
  endtask

  task automatic test_log_full();
    bit got; int n; logic [7:0] op; logic [3:0] code; logic [15:0] tag;
    cfg_mode = 2'd0; log_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_cmd(8'h58, 68'hA0 + 68'(i), 16'h0A00 + 16'(i), 1);
      wait_rsp(20, got, n, op, code, tag);
      tests++;
      if (got !== 1'b1 || code !== 4'h0) begin
        fails++; $display("FAIL full_fill%0d: got=%b code=%h required 1/0", i, got, code);
      end
    end
    send_cmd(8'h58, 68'hA4, 16'h0A04, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || code !== 4'h2) begin
      fails++; $display("FAIL full_retry: got=%b code=%h required 1/2", got, code);
    end
    // Pop lands on the same edge as the decision: still retry, nothing pushed
    send_cmd(8'h58, 68'hA4, 16'h0A04, 1);
    repeat (3) @(negedge clk);
    tests++;
    if (log_src !== 64'hA0) begin
      fails++; $display("FAIL full_head: src=%h required a0", log_src);
    end
    log_ready = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (tlx_rsp_valid !== 1'b1 || tlx_rsp_code !== 4'h2) begin
      fails++; $display("FAIL full_pop_same_edge: valid=%b code=%h required 1/2", tlx_rsp_valid, tlx_rsp_code);
    end
    @(negedge clk);
    log_ready = 1'b0;
    send_cmd(8'h58, 68'hA4, 16'h0A04, 1);
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b1 || code !== 4'h0) begin
      fails++; $display("FAIL full_resend: got=%b code=%h required 1/0", got, code);
    end
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (log_valid !== 1'b1 || log_src !== 64'hA0 + 64'(i)) begin
        fails++; $display("FAIL full_order%0d: valid=%b src=%h required 1/%h", i, log_valid, log_src, 64'hA0 + 64'(i));
      end
      log_ready = 1'b1;
      @(negedge clk);
      log_ready = 1'b0;
    end
    tests++;
    if (log_valid !== 1'b0 || delivered_cnt !== 32'd10) begin
      fails++; $display("FAIL full_final: valid=%b cnt=%0d required 0/10", log_valid, delivered_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit got; int n; logic [7:0] op; logic [3:0] code; logic [15:0] tag;
    send_cmd(8'h58, 68'h99, 16'h0999, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || delivered_cnt !== 32'd0 || err_overlap !== 1'b0) begin
      fails++; $display("FAIL midreset_state: busy=%b cnt=%0d err=%b required 0/0/0",
                        busy, delivered_cnt, err_overlap);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_rsp(20, got, n, op, code, tag);
    tests++;
    if (got !== 1'b0) begin
      fails++; $display("FAIL midreset_lost: rsp tag=%h required none", tag);
    end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1_retry();
    test_mode2(1'b0, 32'd3);
    test_mode2(1'b1, 32'd4);
    test_failed();
    test_ignore_opcode();
    test_back_to_back();
    test_log_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/interrupt_responder.md
Name: interrupt_responder

Overview:
TLX-side responder for AP interrupt requests. It accepts intrp_req commands on the AFU->TLX command interface and returns intrp_resp, plus intrp_rdy when required, according to a programmable policy. It also logs each delivered interrupt into a small FIFO. It sits opposite the AFU interrupt requester in unit benches and the loopback/sim host model, and exercises the done, retry, pending and failed paths.

Parameters:
RSP_LATENCY, 4, cycles from command acceptance to tlx_rsp_valid; legal range 1..255
RDY_DELAY, 16, cycles from the pending response to intrp_rdy; legal range 1..65535
LOG_DEPTH, 4, entries in the delivered-interrupt log FIFO; power of 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
tlx_cmd_valid  in  1  command strobe, one cycle per command
tlx_cmd_opcode  in  8  command opcode
tlx_cmd_obj  in  68  [63:0] interrupt source; [67:64] must be 0
tlx_cmd_afutag  in  16  tag, echoed in every response
tlx_cmd_pasid  in  20  PASID, logged
tlx_cmd_actag  in  12  acTag, logged
tlx_rsp_valid  out  1  response strobe, one cycle
tlx_rsp_opcode  out  8  0x0C intrp_resp or 0x1A intrp_rdy
tlx_rsp_code  out  4  0x0 done, 0x2 retry, 0x4 pending, 0xE failed
tlx_rsp_afutag  out  16  echoed tag
cfg_mode  in  2  0 = always done; 1 = retry N then done; 2 = pending then done; 3 = always failed
cfg_retry_num  in  4  N for mode 1
cfg_rdy_retry  in  1  mode 2: first intrp_rdy carries retry instead of done
log_valid  out  1  log FIFO not empty
log_ready  in  1  pop on log_valid & log_ready
log_src  out  64  head entry source
log_pasid  out  20  head entry PASID
log_actag  out  12  head entry acTag
busy  out  1  a command is in flight (state != IDLE)
err_overlap  out  1  sticky: command dropped because busy
delivered_cnt  out  32  count of done intrp_resp; wraps at 2^32

Behaviour:
- Reset: all outputs 0. State IDLE; FIFO empty; retry_cnt = 0; pend_served = 0; rdy_retry_used = 0.
- Accepted opcodes: 0x58..0x5B. Any other opcode is ignored, with no error flagged.
- Command acceptance: tlx_cmd_valid & legal opcode & state IDLE. Latch afutag, obj, pasid and actag. Sample cfg_* at this cycle.
- Command arriving while busy: dropped, no response, err_overlap set to 1 until reset.
- State machine, one-hot:
  - IDLE -> DELAY on acceptance. Load the latency counter with RSP_LATENCY-1.
  - DELAY: count down; at 0 go to RESP.
  - RESP: tlx_rsp_valid=1 for one cycle, opcode 0x0C, code as decided below. Then go to RDY_WAIT if the code was pending, else IDLE.
  - RDY_WAIT: count down RDY_DELAY-1 to 0, then go to RDY.
  - RDY: tlx_rsp_valid=1, opcode 0x1A, code 0x2 if cfg_rdy_retry & ~rdy_retry_used (then set rdy_retry_used), else 0x0. Go to IDLE.
- Response timing: accepted at edge T -> tlx_rsp_valid high during cycle T+RSP_LATENCY. intrp_rdy is high RDY_DELAY cycles after the resp cycle.
- Code decision, in priority order:
  1. Opcode != 0x58, or obj[67:64] != 0 -> failed.
  2. Mode 3 -> failed.
  3. Mode 1 & retry_cnt < cfg_retry_num -> retry; retry_cnt++.
  4. Mode 2 & ~pend_served -> pending; set pend_served.
  5. FIFO full -> retry. This path leaves retry_cnt unchanged.
  6. Otherwise done.
- On done: push the latched {src, pasid, actag} into the FIFO, delivered_cnt++, clear retry_cnt, pend_served and rdy_retry_used.
- Failed does not clear the retry/pending state.
- cfg_retry_num = 0 in mode 1 behaves as mode 0.
- FIFO: push on done, pop on handshake. Push and pop in the same cycle when full is legal: the "full" decision is taken before the pop, so the response is retry and nothing is pushed.
- Reset mid-operation: returns to IDLE immediately; any pending response is lost.

Test Plan:
- Mode 0, cmd opcode 0x58, obj=0x1234, afutag=0xC000 at cycle 10 -> rsp_valid at cycle 14, opcode 0x0C, code 0x0, afutag 0xC000. log_src=0x1234, delivered_cnt=1.
- Mode 1, N=2, requester re-sends after each response -> codes 0x2, 0x2, 0x0. Exactly one log entry.
- Mode 2, cfg_rdy_retry=0 -> resp code 0x4, then intrp_rdy 0x1A/0x0 exactly 16 cycles later. Re-sent cmd gets 0x0.
- Mode 2, cfg_rdy_retry=1 -> pending, then intrp_rdy code 0x2. Re-sent cmd gets done with no further pending.
- Opcode 0x5A, or obj[67:64]=0x1, or mode 3 -> code 0xE, no log push. Second cmd during DELAY -> dropped, err_overlap=1.
- log_ready=0, 5 interrupts with LOG_DEPTH=4 -> 4 done, 5th gets retry. Raise log_ready and re-send -> done, log order preserved.
